// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle for the SRAM slave.
// Carries one master's address/data phase signals and the slave's response.
interface ahb_sram_slave_if;
   logic        hsel;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;

   modport master (
      output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/ahb_sram_slave.sv
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
  parameter int          ADDR_WORDS_LOG2 = 14,
  parameter int          WAIT_STATES     = 0,
  parameter              MEM_INIT_FILE   = ""
) (
  input logic             clk,
  input logic             resetn,
  ahb_sram_slave_if.slave bus
);
  localparam int          N         = ADDR_WORDS_LOG2;
  localparam logic [32:0] SPAN      = 33'd4 << N;
  localparam logic [3:0]  WS_RELOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic [31:0] mem [2**N];

  logic         dp_valid;
  logic         dp_write;
  logic [N-1:0] dp_idx;
  logic [3:0]   dp_be;
  logic [31:0]  rdata;

  logic [31:0]  off;
  logic [N-1:0] a_idx;
  logic [N-1:0] rd_idx;
  logic [3:0]   be;
  logic         aligned, legal, accept, ready_int;
  logic         wr_en, load_rd;
  logic [31:0]  rd_word;
  logic         unused;

  assign unused = ^{bus.hburst, bus.htrans[0]};

  always_comb begin
    off     = bus.haddr - BASE_ADDR;
    a_idx   = off[N+1:2];
    aligned = 1'b1;
    be      = 4'b0000;
    case (bus.hsize)
      3'd0: be = 4'b0001 << bus.haddr[1:0];
      3'd1: begin
        be      = bus.haddr[1] ? 4'b1100 : 4'b0011;
        aligned = ~bus.haddr[0];
      end
      3'd2: begin
        be      = 4'b1111;
        aligned = (bus.haddr[1:0] == 2'b00);
      end
      default: be = 4'b0000;
    endcase
    legal = ({1'b0, off} < SPAN) && (bus.hsize <= 3'd2) && aligned;
  end

  assign ready_int  = (state == IDLE) || (state == ERR2);
  assign accept     = ready_int && bus.hsel && bus.htrans[1];
  assign bus.hready = ready_int;
  assign bus.hresp  = ((state == ERR1) || (state == ERR2)) ? 2'b01 : 2'b00;
  assign bus.hrdata = rdata;

  assign wr_en   = resetn && (state == IDLE) && dp_valid && dp_write;
  assign load_rd = (accept && legal && !bus.hwrite && (WAIT_STATES == 0)) ||
                   ((state == WAIT) && (cnt == 4'd0) && dp_valid && !dp_write);
  assign rd_idx  = (state == WAIT) ? dp_idx : a_idx;

  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_en && (dp_idx == rd_idx)) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i]) rd_word[8*i +: 8] = bus.hwdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, ERR2: begin
        state_nxt = IDLE;
        if (accept) begin
          if (!legal) begin
            state_nxt = ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WS_RELOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_be    <= 4'b0000;
      rdata    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (ready_int) begin
        dp_valid <= accept && legal;
        if (accept) begin
          dp_write <= bus.hwrite;
          dp_idx   <= a_idx;
          dp_be    <= be;
        end
      end
      if (load_rd) rdata <= rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_be[i]) mem[dp_idx][8*i +: 8] <= bus.hwdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a three-wait instance share one
// master driver; hsel picks the target. Read results are scoreboarded.
module tb_ahb_sram_slave;
   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [2:0]  size;
      logic [31:0] data;   // write data, or expected read data
   } xfer_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   logic        cur = 1'b0;
   logic [31:0] m_haddr = 32'd0;
   logic [1:0]  m_htrans = 2'b00;
   logic        m_hwrite = 1'b0;
   logic [2:0]  m_hsize = 3'd2;
   logic [31:0] m_hwdata = 32'd0;

   ahb_sram_slave_if b0 ();
   ahb_sram_slave_if b3 ();

   assign b0.hsel   = (cur == 1'b0);
   assign b3.hsel   = (cur == 1'b1);
   assign b0.haddr  = m_haddr;   assign b3.haddr  = m_haddr;
   assign b0.htrans = m_htrans;  assign b3.htrans = m_htrans;
   assign b0.hwrite = m_hwrite;  assign b3.hwrite = m_hwrite;
   assign b0.hsize  = m_hsize;   assign b3.hsize  = m_hsize;
   assign b0.hburst = 3'b000;    assign b3.hburst = 3'b000;
   assign b0.hwdata = m_hwdata;  assign b3.hwdata = m_hwdata;

   ahb_sram_slave #(.WAIT_STATES(0)) dut0 (.clk(clk), .resetn(resetn), .bus(b0.slave));
   ahb_sram_slave #(.WAIT_STATES(3)) dut3 (.clk(clk), .resetn(resetn), .bus(b3.slave));

   logic        ready;
   logic [1:0]  resp;
   logic [31:0] rdata;
   assign ready = cur ? b3.hready : b0.hready;
   assign resp  = cur ? b3.hresp  : b0.hresp;
   assign rdata = cur ? b3.hrdata : b0.hrdata;

   int          errors = 0;
   int          checks = 0;
   xfer_t       xq[$];
   logic [31:0] sb[$];
   logic [31:0] last_rd [2];

   function automatic xfer_t mk(logic [31:0] a, logic w, logic [2:0] s, logic [31:0] d);
      xfer_t x;
      x.addr = a; x.wr = w; x.size = s; x.data = d;
      return x;
   endfunction

   function automatic logic [31:0] val(int i);
      return 32'hA5A5_0000 ^ (i * 32'h0101_0013);
   endfunction

   // Runs everything in xq back to back; expects ws wait cycles per transfer
   task automatic pipe(input int ws);
      int k = 0, dp = -1, waits = 0, guard = 0;
      logic ready_s;
      logic [31:0] exp;
      while (k < xq.size() || dp >= 0) begin
         if (k < xq.size()) begin
            m_htrans = 2'b10; m_haddr = xq[k].addr;
            m_hwrite = xq[k].wr; m_hsize = xq[k].size;
         end else begin
            m_htrans = 2'b00;
         end
         if (dp >= 0) m_hwdata = xq[dp].data;
         @(negedge clk);
         if (dp >= 0 && !ready) begin
            waits++;
         end else if (dp >= 0) begin
            checks++;
            if (waits != ws || resp !== 2'b00) begin
               errors++;
               $display("FAIL xfer%0d_phase addr=%h: waits=%0d hresp=%b, need waits=%0d hresp=00",
                        dp, xq[dp].addr, waits, resp, ws);
            end
            checks++;
            if (!xq[dp].wr) begin
               exp = sb.pop_front();
               if (rdata !== exp) begin
                  errors++;
                  $display("FAIL read addr=%h: hrdata=%h, need %h", xq[dp].addr, rdata, exp);
               end
               last_rd[cur] = exp;
            end else if (rdata !== last_rd[cur]) begin
               errors++;
               $display("FAIL hrdata_hold addr=%h: hrdata=%h, need %h", xq[dp].addr, rdata, last_rd[cur]);
            end
            waits = 0;
         end
         ready_s = ready;
         @(posedge clk); #1;
         if (ready_s) begin
            if (k < xq.size()) begin
               if (!xq[k].wr) sb.push_back(xq[k].data);
               dp = k;
               k++;
            end else begin
               dp = -1;
            end
         end
         guard++;
         if (guard > 200) begin
            checks++; errors++;
            $display("FAIL pipe_timeout: %0d cycles, need completion", guard);
            break;
         end
      end
      m_htrans = 2'b00;
      xq.delete();
      sb.delete();
   endtask

   task automatic err(input logic [31:0] a, input logic [2:0] s);
      m_htrans = 2'b10; m_haddr = a; m_hwrite = 1'b1; m_hsize = s;
      @(posedge clk); #1;
      m_htrans = 2'b00; m_hwdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0 || resp !== 2'b01) begin
         errors++;
         $display("FAIL err1 addr=%h size=%0d: hready=%b hresp=%b, need 0/01", a, s, ready, resp);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || resp !== 2'b01) begin
         errors++;
         $display("FAIL err2 addr=%h size=%0d: hready=%b hresp=%b, need 1/01", a, s, ready, resp);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || resp !== 2'b00) begin
         errors++;
         $display("FAIL err_exit addr=%h: hready=%b hresp=%b, need 1/00", a, ready, resp);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      checks += 2;
      if (b0.hready !== 1'b1 || b0.hresp !== 2'b00 || b0.hrdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_ws0: hready=%b hresp=%b hrdata=%h, need 1/00/0", b0.hready, b0.hresp, b0.hrdata);
      end
      if (b3.hready !== 1'b1 || b3.hresp !== 2'b00 || b3.hrdata !== 32'd0) begin
         errors++;
         $display("FAIL reset_ws3: hready=%b hresp=%b hrdata=%h, need 1/00/0", b3.hready, b3.hresp, b3.hrdata);
      end
      last_rd[0] = 32'd0; last_rd[1] = 32'd0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_wait();
      cur = 1'b0;
      xq.push_back(mk(32'h4000_0010, 1'b1, 3'd2, 32'hDEAD_BEEF));
      xq.push_back(mk(32'h4000_0010, 1'b0, 3'd2, 32'hDEAD_BEEF));
      pipe(0);
   endtask

   task automatic test_subword();
      cur = 1'b0;
      xq.push_back(mk(32'h4000_0020, 1'b1, 3'd2, 32'h0000_0000));
      xq.push_back(mk(32'h4000_0021, 1'b1, 3'd0, 32'h0000_AA00));
      xq.push_back(mk(32'h4000_0022, 1'b1, 3'd1, 32'h1234_0000));
      xq.push_back(mk(32'h4000_0020, 1'b0, 3'd2, 32'h1234_AA00));
      xq.push_back(mk(32'h4000_0023, 1'b0, 3'd0, 32'h1234_AA00));
      xq.push_back(mk(32'h4000_0020, 1'b1, 3'd0, 32'h0000_0077));
      xq.push_back(mk(32'h4000_0020, 1'b0, 3'd2, 32'h1234_AA77));
      pipe(0);
   endtask

   task automatic test_bypass();
      cur = 1'b0;
      xq.push_back(mk(32'h4000_0040, 1'b1, 3'd2, 32'h0000_0000));
      xq.push_back(mk(32'h4000_0040, 1'b1, 3'd2, 32'h5555_5555));
      xq.push_back(mk(32'h4000_0040, 1'b0, 3'd2, 32'h5555_5555));
      pipe(0);
   endtask

   task automatic test_back_to_back();
      cur = 1'b0;
      for (int i = 0; i < 8; i++) xq.push_back(mk(32'h4000_0400 + 4*i, 1'b1, 3'd2, val(i)));
      for (int i = 7; i >= 0; i--) xq.push_back(mk(32'h4000_0400 + 4*i, 1'b0, 3'd2, val(i)));
      pipe(0);
      // the deselected zero-wait slave must ignore this transfer
      cur = 1'b1;
      xq.push_back(mk(32'h4000_0400, 1'b1, 3'd2, 32'hBAD0_BAD0));
      pipe(3);
      cur = 1'b0;
      xq.push_back(mk(32'h4000_0400, 1'b0, 3'd2, val(0)));
      pipe(0);
   endtask

   task automatic test_wait_states();
      cur = 1'b1;
      xq.push_back(mk(32'h4000_0100, 1'b1, 3'd2, 32'hCAFE_F00D));
      xq.push_back(mk(32'h4000_0100, 1'b0, 3'd2, 32'hCAFE_F00D));
      xq.push_back(mk(32'h4000_0104, 1'b1, 3'd2, 32'h0123_4567));
      xq.push_back(mk(32'h4000_0105, 1'b1, 3'd0, 32'h0000_9900));
      xq.push_back(mk(32'h4000_0104, 1'b0, 3'd2, 32'h0123_9967));
      pipe(3);
   endtask

   task automatic test_errors();
      cur = 1'b0;
      xq.push_back(mk(32'h4000_FFFC, 1'b1, 3'd2, 32'h0F0F_0F0F));
      xq.push_back(mk(32'h4000_0000, 1'b1, 3'd2, 32'h1212_1212));
      xq.push_back(mk(32'h4000_0030, 1'b1, 3'd2, 32'h3030_3030));
      pipe(0);
      err(32'h3FFF_FFFC, 3'd2);
      err(32'h4001_0000, 3'd2);
      err(32'h4000_0012, 3'd2);
      err(32'h4000_0030, 3'd3);
      err(32'h4000_0031, 3'd1);
      xq.push_back(mk(32'h4000_FFFC, 1'b0, 3'd2, 32'h0F0F_0F0F));
      xq.push_back(mk(32'h4000_0000, 1'b0, 3'd2, 32'h1212_1212));
      xq.push_back(mk(32'h4000_0010, 1'b0, 3'd2, 32'hDEAD_BEEF));
      xq.push_back(mk(32'h4000_0030, 1'b0, 3'd2, 32'h3030_3030));
      pipe(0);
      cur = 1'b1;
      err(32'h4000_0102, 3'd2);
      xq.push_back(mk(32'h4000_0100, 1'b0, 3'd2, 32'hCAFE_F00D));
      pipe(3);
   endtask

   task automatic test_reset_mid_wait();
      cur = 1'b1;
      xq.push_back(mk(32'h4000_0200, 1'b1, 3'd2, 32'h1111_1111));
      pipe(3);
      m_htrans = 2'b10; m_haddr = 32'h4000_0200; m_hwrite = 1'b1; m_hsize = 3'd2;
      @(posedge clk); #1;
      m_htrans = 2'b00; m_hwdata = 32'hEEEE_EEEE;
      @(negedge clk);
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_wait_entry: hready=%b, need 0", ready);
      end
      @(posedge clk); #1 resetn = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || resp !== 2'b00 || rdata !== 32'd0) begin
         errors++;
         $display("FAIL mid_wait_reset: hready=%b hresp=%b hrdata=%h, need 1/00/0", ready, resp, rdata);
      end
      last_rd[0] = 32'd0; last_rd[1] = 32'd0;
      @(posedge clk); #1;
      xq.push_back(mk(32'h4000_0200, 1'b0, 3'd2, 32'h1111_1111));
      pipe(3);
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_subword();
      test_bypass();
      test_back_to_back();
      test_wait_states();
      test_errors();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
